// File: rtl/fetch_replay_gen.sv
// Fetch address generator with stall replay and catch-up.
// Re-emits the oldest in-flight fetch while the backend stalls.
module fetch_replay_gen #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0400,
  parameter int unsigned DEPTH        = 2,
  parameter logic [7:0]  MISALIGN_EXC = 8'h84
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        stall,
  input  logic        branch,
  input  logic [31:0] branch_tgt,
  input  logic        interrupt,
  input  logic [31:0] interrupt_vector,
  input  logic        rfe_in_wb,
  input  logic [31:0] epc,
  output logic [31:0] fetch_addr,
  output logic [31:0] pc_out,
  output logic [31:0] slot_id_out,
  output logic        bubble_out,
  output logic [7:0]  exc_out,
  output logic        replaying
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [2:0]  CU_INIT = 3'(DEPTH - 1);

  logic [31:0] pc_q, pc_d;
  logic [31:0] slot_q, slot_d;
  logic [2:0]  cu_q, cu_d;

  logic        stall_fetch;
  logic        cu_act;
  logic        redirect;
  logic [31:0] cu_ext;
  logic [31:0] slot_sel;

  assign stall_fetch = stall & ~interrupt & ~rfe_in_wb;
  assign cu_act      = (cu_q != 3'd0);
  assign redirect    = interrupt | rfe_in_wb | branch;
  assign cu_ext      = {29'd0, cu_q};
  assign replaying   = stall_fetch | cu_act;

  // Pick the address/slot: oldest in flight, catch-up, or new work.
  always_comb begin
    fetch_addr = pc_q;
    slot_sel   = slot_q;
    if (stall_fetch) begin
      fetch_addr = pc_q - (DEPTH_W << 2);
      slot_sel   = slot_q - DEPTH_W;
    end else if (cu_act) begin
      fetch_addr = pc_q - (cu_ext << 2);
      slot_sel   = slot_q - cu_ext;
    end
  end

  // Next PC, slot sequence and catch-up counter.
  always_comb begin
    pc_d   = pc_q;
    slot_d = slot_q;
    cu_d   = cu_q;
    if (stall_fetch) begin
      cu_d = CU_INIT;
    end else begin
      if (interrupt)      pc_d = interrupt_vector;
      else if (rfe_in_wb) pc_d = epc;
      else if (branch)    pc_d = branch_tgt;
      else if (!cu_act)   pc_d = pc_q + 32'd4;
      if (!cu_act) slot_d = slot_q + 32'd1;
      if (redirect)    cu_d = 3'd0;
      else if (cu_act) cu_d = cu_q - 3'd1;
    end
  end

  // State and registered outputs; outputs hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      slot_q      <= 32'd0;
      cu_q        <= 3'd0;
      pc_out      <= 32'd0;
      slot_id_out <= 32'd0;
      bubble_out  <= 1'b1;
      exc_out     <= 8'd0;
    end else if (clk_en) begin
      pc_q   <= pc_d;
      slot_q <= slot_d;
      cu_q   <= cu_d;
      if (!stall_fetch) begin
        pc_out      <= fetch_addr;
        slot_id_out <= slot_sel;
        bubble_out  <= redirect;
        exc_out     <= (fetch_addr[1:0] != 2'b00) ? MISALIGN_EXC : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_replay_gen.sv
// Scoreboard bench for fetch_replay_gen at DEPTH 3, 4 and 1.
// Stimulus pushes expectations; a negedge monitor checks them.
module tb_fetch_replay_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        stall = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_tgt = 32'h0;
  logic        interrupt = 1'b0;
  logic [31:0] interrupt_vector = 32'h0000_0100;
  logic        rfe_in_wb = 1'b0;
  logic [31:0] epc = 32'h0000_0200;

  logic [31:0] fa  [3];
  logic [31:0] pco [3];
  logic [31:0] slo [3];
  logic        bub [3];
  logic [7:0]  exc [3];
  logic        rep [3];

  always #5 clk = ~clk;

  fetch_replay_gen #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall),
    .branch(branch), .branch_tgt(branch_tgt),
    .interrupt(interrupt), .interrupt_vector(interrupt_vector),
    .rfe_in_wb(rfe_in_wb), .epc(epc),
    .fetch_addr(fa[0]), .pc_out(pco[0]), .slot_id_out(slo[0]),
    .bubble_out(bub[0]), .exc_out(exc[0]), .replaying(rep[0]));

  fetch_replay_gen #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall),
    .branch(branch), .branch_tgt(branch_tgt),
    .interrupt(interrupt), .interrupt_vector(interrupt_vector),
    .rfe_in_wb(rfe_in_wb), .epc(epc),
    .fetch_addr(fa[1]), .pc_out(pco[1]), .slot_id_out(slo[1]),
    .bubble_out(bub[1]), .exc_out(exc[1]), .replaying(rep[1]));

  fetch_replay_gen #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .stall(stall),
    .branch(branch), .branch_tgt(branch_tgt),
    .interrupt(interrupt), .interrupt_vector(interrupt_vector),
    .rfe_in_wb(rfe_in_wb), .epc(epc),
    .fetch_addr(fa[2]), .pc_out(pco[2]), .slot_id_out(slo[2]),
    .bubble_out(bub[2]), .exc_out(exc[2]), .replaying(rep[2]));

  typedef struct {
    int          id;
    int          sel;
    logic [31:0] fa;
    logic        rep;
    logic [31:0] pco;
    logic [31:0] slo;
    logic        bub;
    logic [7:0]  exc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  task automatic chk(input string nm, input int id,
                     input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h exp=%h", nm, id, got, exp);
    end
  endtask

  // Monitor: compare the selected DUT against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("fetch_addr", e.id, fa[e.sel], e.fa);
      chk("replaying", e.id, 32'(rep[e.sel]), 32'(e.rep));
      chk("pc_out", e.id, pco[e.sel], e.pco);
      chk("slot_id_out", e.id, slo[e.sel], e.slo);
      chk("bubble_out", e.id, 32'(bub[e.sel]), 32'(e.bub));
      chk("exc_out", e.id, 32'(exc[e.sel]), 32'(e.exc));
    end
  end

  task automatic step(input int sel, input logic r, input logic ce,
                      input logic st, input logic br, input logic ir,
                      input logic rf, input logic [31:0] tgt,
                      input logic [31:0] efa, input logic erep,
                      input logic [31:0] epco, input logic [31:0] eslo,
                      input logic ebub, input logic [7:0] eexc);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; clk_en = ce; stall = st; branch = br;
    interrupt = ir; rfe_in_wb = rf; branch_tgt = tgt;
    e.id = n; e.sel = sel; e.fa = efa; e.rep = erep;
    e.pco = epco; e.slo = eslo; e.bub = ebub; e.exc = eexc;
    q.push_back(e);
    n++;
  endtask

  initial begin
    // DEPTH=3: reset and run
    step(0,1,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h404,0, 32'h400,0,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h408,0, 32'h404,1,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h40C,0, 32'h408,2,0,8'h0);
    // stall 4 cycles at pc=0x410, slot_seq=4
    for (int i = 0; i < 4; i++)
      step(0,0,1,1,0,0,0,0, 32'h404,1, 32'h40C,3,0,8'h0);
    // release: catch-up then new work
    step(0,0,1,0,0,0,0,0, 32'h408,1, 32'h40C,3,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h40C,1, 32'h408,2,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h410,0, 32'h40C,3,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h414,0, 32'h410,4,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h418,0, 32'h414,5,0,8'h0);
    // branch on first catch-up cycle
    step(0,0,1,1,0,0,0,0, 32'h410,1, 32'h418,6,0,8'h0);
    step(0,0,1,0,1,0,0,32'h800, 32'h414,1, 32'h418,6,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h800,0, 32'h414,5,1,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h804,0, 32'h800,7,0,8'h0);
    // interrupt overrides stall
    step(0,0,1,1,0,1,0,0, 32'h808,0, 32'h804,8,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h100,0, 32'h808,9,1,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h104,0, 32'h100,10,0,8'h0);
    // misaligned branch target
    step(0,0,1,0,1,0,0,32'h802, 32'h108,0, 32'h104,11,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h802,0, 32'h108,12,1,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h806,0, 32'h802,13,0,8'h84);
    // reset pulse mid-stream
    step(0,1,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    // clock enable low freezes state, cu_cnt included
    step(0,0,0,0,0,0,0,0, 32'h404,0, 32'h400,0,0,8'h0);
    step(0,0,0,1,0,0,0,0, 32'h3F8,1, 32'h400,0,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h404,0, 32'h400,0,0,8'h0);
    // rfe overrides stall
    step(0,0,1,1,0,0,1,0, 32'h408,0, 32'h404,1,0,8'h0);
    step(0,0,1,0,0,0,0,0, 32'h200,0, 32'h408,2,1,8'h0);

    // DEPTH=4: stall re-asserted mid catch-up
    step(1,1,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h404,0, 32'h400,0,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h408,0, 32'h404,1,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h40C,0, 32'h408,2,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h410,0, 32'h40C,3,0,8'h0);
    step(1,0,1,1,0,0,0,0, 32'h404,1, 32'h410,4,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h408,1, 32'h410,4,0,8'h0);
    step(1,0,1,1,0,0,0,0, 32'h404,1, 32'h408,2,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h408,1, 32'h408,2,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h40C,1, 32'h408,2,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h410,1, 32'h40C,3,0,8'h0);
    step(1,0,1,0,0,0,0,0, 32'h414,0, 32'h410,4,0,8'h0);

    // DEPTH=1: release resumes directly at pc
    step(2,1,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(2,0,1,0,0,0,0,0, 32'h400,0, 32'h0,0,1,8'h0);
    step(2,0,1,0,0,0,0,0, 32'h404,0, 32'h400,0,0,8'h0);
    step(2,0,1,1,0,0,0,0, 32'h404,1, 32'h404,1,0,8'h0);
    step(2,0,1,0,0,0,0,0, 32'h408,0, 32'h404,1,0,8'h0);
    step(2,0,1,0,0,0,0,0, 32'h40C,0, 32'h408,2,0,8'h0);

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_replay_gen.md
# fetch_replay_gen

Parametrised fetch address generator for the frontend: produces the instruction fetch address for memory/TLB lookup, and the matching PC, slot id, bubble and exception into the frontend pipe. It handles redirects from branch, interrupt and rfe. On a backend stall it replays the oldest in-flight fetch for a configurable number of registered frontend stages (`DEPTH`), then emits a multi-cycle catch-up sequence on release. It replaces the fixed two-stage replay generator and feeds the frontend register stages ahead of decode.

## Interface
Parameters:
- `RESET_PC`, default 32'h00000400: PC loaded on reset.
- `DEPTH`, default 2: number of registered frontend stages between this block and decode. Legal range 1..7.
- `MISALIGN_EXC`, default 8'h84: exception code for a misaligned fetch address.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `clk_en`  in  1: global clock enable. When low, no state changes.
- `stall`  in  1: backend frontend-stall request.
- `branch`, `branch_tgt`  in  1, 32: branch redirect and its target.
- `interrupt`, `interrupt_vector`  in  1, 32: interrupt redirect and its vector.
- `rfe_in_wb`, `epc`  in  1, 32: return-from-exception redirect and its target.
- `fetch_addr`  out  32: combinational fetch address.
- `pc_out`  out  32 (reg): registered fetch PC.
- `slot_id_out`  out  32 (reg): registered slot id.
- `bubble_out`  out  1 (reg): marks the emitted slot invalid.
- `exc_out`  out  8 (reg): fetch exception code.
- `replaying`  out  1: combinational; high during stall replay or catch-up.

## Operation
Internal state:
- `pc` (32): next new fetch address.
- `slot_seq` (32): next new slot id.
- `cu_cnt` (3 bits): remaining catch-up steps.

Derived signals:
- `stall_fetch = stall && !interrupt && !rfe_in_wb`. Interrupt and rfe override stall; branch does not.
- `replaying = stall_fetch || cu_cnt != 0`.

Combinational address and slot selection:
- If `stall_fetch`: `fetch_addr = pc - 4*DEPTH`, slot = `slot_seq - DEPTH`.
- Else if `cu_cnt != 0`: `fetch_addr = pc - 4*cu_cnt`, slot = `slot_seq - cu_cnt`.
- Else: `fetch_addr = pc`, slot = `slot_seq`.
- All arithmetic is modulo 2^32. Wrap-around is allowed and not flagged.

Update on each posedge with `clk_en=1`:
- If `stall_fetch`:
  - `pc`, `slot_seq` and all registered outputs hold.
  - `cu_cnt <= DEPTH-1`. This restart also applies if the stall arrives in the middle of a catch-up.
- Else, registered outputs:
  - `pc_out <= fetch_addr`.
  - `slot_id_out <=` selected slot.
  - `bubble_out <= interrupt || rfe_in_wb || branch`.
  - `exc_out <= (fetch_addr[1:0] != 0) ? MISALIGN_EXC : 0`.
- Else, `pc` priority: `interrupt_vector` > `epc` > `branch_tgt` > (hold if `cu_cnt != 0`) > `pc + 4`.
- Else, `slot_seq`: holds if `cu_cnt != 0`, otherwise increments by 1. A redirect does not change this rule.
- Else, `cu_cnt`: cleared to 0 on any redirect, otherwise decremented if nonzero.

Other rules:
- `DEPTH=1`: there is no catch-up; release resumes directly at `pc`.
- Slot ids are strictly monotonic for new work. Replay and catch-up re-emit older ids only, so downstream dedup can drop replays by ordering.
- `rst` asserted, at any time including mid-replay, sets:
  - `pc=RESET_PC`, `slot_seq=0`, `cu_cnt=0`.
  - `pc_out=0`, `slot_id_out=0`, `bubble_out=1`, `exc_out=0`.

## Timing
- `fetch_addr` and `replaying` are combinational from state plus `stall`, `interrupt` and `rfe_in_wb`. Memory samples `fetch_addr` in the same cycle.
- Registered outputs appear one cycle after the address: `pc_out` equals the previous cycle's `fetch_addr` whenever the previous cycle was not `stall_fetch`.
- Stall release costs exactly `DEPTH-1` catch-up cycles before new PCs resume.
- First redirected address is presented one cycle after the redirect input, and is emitted with `bubble_out=0` unless another redirect occurs.
- `clk_en=0` freezes everything, including `cu_cnt`. Combinational outputs still track the inputs.
- Reset release: first `fetch_addr` is `RESET_PC`, with slot 0.

## Test plan
- Reset, run with DEPTH=3 -> `fetch_addr` sequence 0x400, 0x404, 0x408. `slot_id_out` 0, 1, 2, each one cycle later. `bubble_out=0` from the second edge onward.
- DEPTH=3: `stall` held 4 cycles with `pc`=0x410, `slot_seq`=4 -> `fetch_addr`=0x404 (slot 1) throughout, registered outputs frozen. Release -> 0x408/slot 2, then 0x40C/slot 3, then 0x410/slot 4, then 0x414/slot 5.
- DEPTH=3: `branch` to 0x800 on the first catch-up cycle -> that slot emitted with `bubble_out=1`. Next cycle `fetch_addr`=0x800 with slot = the held `slot_seq`. `cu_cnt` cleared.
- `interrupt` (vector 0x100) asserted together with `stall` -> stall ignored, next `fetch_addr`=0x100, `bubble_out=1`, `replaying=0`.
- Stall re-asserted mid-catch-up (DEPTH=4) -> address returns to `pc`-16. Release replays a full 3-cycle catch-up.
- `branch_tgt`=0x802 -> `exc_out`=0x84 with `pc_out`=0x802. Then `rst` pulse mid-stream -> all outputs at reset values, `fetch_addr`=0x400, slot 0. Also check DEPTH=1: release goes straight to `pc`.
